// File: rtl/mcoi_reset_sequencer.sv
// Staged reset sequencer: merges synchronised fault sources, filters for stability,
// then releases N_OUT resets in ascending order before flagging ready.
module mcoi_reset_sequencer #(
    parameter int N_SRC       = 4,
    parameter int N_OUT       = 3,
    parameter int FILTER_LEN  = 16,
    parameter int STAGE_DELAY = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int RCNT_W      = 16
) (
    input  logic              clk_ik,
    input  logic              rst_ir,
    input  logic              cen_ie,
    input  logic [N_SRC-1:0]  src_fault_i,
    input  logic [N_SRC-1:0]  src_mask_i,
    input  logic              force_rst_i,
    input  logic              clear_i,
    output logic [N_OUT-1:0]  rst_o,
    output logic              ready_o,
    output logic [N_SRC-1:0]  fault_latched_o,
    output logic [RCNT_W-1:0] restart_cnt_o
);

    // state   | meaning
    // HOLD    | all resets asserted, waiting for a fault-free enabled edge
    // FILTER  | counting FILTER_LEN consecutive fault-free cycles
    // RELEASE | deasserting one stage every STAGE_DELAY cycles
    // RUN     | all stages released, ready asserted
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_FILTER  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam int CNT_MAX = (FILTER_LEN > STAGE_DELAY) ? FILTER_LEN : STAGE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STG_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] FILT_LD  = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] STG_LD   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(N_OUT - 1);

    logic [N_SRC-1:0]  r_sync [SYNC_STAGES];
    logic [N_SRC-1:0]  w_sf;
    logic              w_fault_any;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [STG_W-1:0]  r_stage, w_stage_nxt;
    logic [N_OUT-1:0]  r_rst, w_rst_nxt;
    logic              r_ready, w_ready_nxt;
    logic [N_SRC-1:0]  r_latched;
    logic [RCNT_W-1:0] r_restart_cnt;
    logic              w_restart;

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= src_fault_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sf        = r_sync[SYNC_STAGES-1];
    assign w_fault_any = (|(w_sf & ~src_mask_i)) | force_rst_i;

    // Fault exit bypasses cen_ie so reset assertion is never delayed.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        if (r_state != ST_HOLD && w_fault_any) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
        end else if (cen_ie) begin
            case (r_state)
                ST_HOLD: begin
                    if (!w_fault_any) begin
                        w_state_nxt = ST_FILTER;
                        w_cnt_nxt   = FILT_LD;
                    end
                end
                ST_FILTER: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = STG_LD;
                        w_stage_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else if (r_stage == LAST_STG) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_stage_nxt = r_stage + STG_W'(1);
                        w_cnt_nxt   = STG_LD;
                    end
                end
                ST_RUN: ;
                default: w_state_nxt = ST_HOLD;
            endcase
        end
    end

    // Outputs decoded from next state and registered so reset lines never glitch.
    always_comb begin
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (w_state_nxt == ST_RUN) begin
            w_rst_nxt   = '0;
            w_ready_nxt = 1'b1;
        end else if (w_state_nxt == ST_RELEASE) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (STG_W'(k) <= w_stage_nxt) w_rst_nxt[k] = 1'b0;
            end
        end
    end

    assign w_restart = w_fault_any && (r_state == ST_RELEASE || r_state == ST_RUN);

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            r_state       <= ST_HOLD;
            r_cnt         <= '0;
            r_stage       <= '0;
            r_rst         <= '1;
            r_ready       <= 1'b0;
            r_restart_cnt <= '0;
            r_latched     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stage   <= w_stage_nxt;
            r_rst     <= w_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_latched <= (clear_i ? '0 : r_latched) | (w_sf & ~src_mask_i);
            if (w_restart && r_restart_cnt != '1) begin
                r_restart_cnt <= r_restart_cnt + RCNT_W'(1);
            end
        end
    end

    assign rst_o           = r_rst;
    assign ready_o         = r_ready;
    assign fault_latched_o = r_latched;
    assign restart_cnt_o   = r_restart_cnt;

endmodule

// File: tb/tb_mcoi_reset_sequencer.sv
// Bench for mcoi_reset_sequencer: progress-count reference model checked every cycle,
// directed bring-up/fault/mask/cen/saturation scenarios, then randomized traffic.
module tb_mcoi_reset_sequencer;

    localparam int N_SRC = 3;
    localparam int N_OUT = 3;
    localparam int FL    = 4;
    localparam int SD    = 8;
    localparam int SS    = 2;
    localparam int PROG_MAX = FL + 1 + N_OUT * SD;

    logic             clk = 1'b0;
    logic             rst_r = 1'b1;
    logic             cen = 1'b1;
    logic [N_SRC-1:0] src = '0;
    logic [N_SRC-1:0] mask = '0;
    logic             force_rst = 1'b0;
    logic             clear = 1'b0;

    logic [N_OUT-1:0] rst_o, s_rst_o;
    logic             ready, s_ready;
    logic [N_SRC-1:0] lat, s_lat;
    logic [15:0]      rcnt;
    logic [2:0]       s_rcnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mcoi_reset_sequencer #(
        .N_SRC(N_SRC), .N_OUT(N_OUT), .FILTER_LEN(FL), .STAGE_DELAY(SD), .SYNC_STAGES(SS), .RCNT_W(16)
    ) dut (
        .clk_ik(clk), .rst_ir(rst_r), .cen_ie(cen), .src_fault_i(src), .src_mask_i(mask),
        .force_rst_i(force_rst), .clear_i(clear), .rst_o(rst_o), .ready_o(ready),
        .fault_latched_o(lat), .restart_cnt_o(rcnt)
    );

    // Narrow restart counter instance so saturation is reachable in a short run.
    mcoi_reset_sequencer #(
        .N_SRC(N_SRC), .N_OUT(N_OUT), .FILTER_LEN(FL), .STAGE_DELAY(SD), .SYNC_STAGES(SS), .RCNT_W(3)
    ) dut_sat (
        .clk_ik(clk), .rst_ir(rst_r), .cen_ie(cen), .src_fault_i(src), .src_mask_i(mask),
        .force_rst_i(force_rst), .clear_i(clear), .rst_o(s_rst_o), .ready_o(s_ready),
        .fault_latched_o(s_lat), .restart_cnt_o(s_rcnt)
    );

    // Reference: m_prog = number of enabled fault-free edges since the last fault.
    logic [N_SRC-1:0] m_sync [SS];
    int               m_prog = 0;
    int               m_raw = 0;
    logic [N_SRC-1:0] m_lat = '0;
    logic             m_valid = 1'b0;
    logic             m_fa;

    assign m_fa = (|(m_sync[SS-1] & ~mask)) | force_rst;

    always @(posedge clk) begin
        if (rst_r) begin
            for (int i = 0; i < SS; i++) m_sync[i] <= '0;
            m_prog  <= 0;
            m_raw   <= 0;
            m_lat   <= '0;
            m_valid <= 1'b1;
        end else begin
            m_sync[0] <= src;
            for (int i = 1; i < SS; i++) m_sync[i] <= m_sync[i-1];
            if (m_fa) begin
                m_prog <= 0;
                if (m_prog > FL) m_raw <= m_raw + 1;
            end else if (cen && m_prog < PROG_MAX) begin
                m_prog <= m_prog + 1;
            end
            m_lat <= (clear ? '0 : m_lat) | (m_sync[SS-1] & ~mask);
        end
    end

    function automatic logic [N_OUT-1:0] exp_rst(input int p);
        logic [N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k] = (p < FL + 1 + k * SD);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model rst_o", 32'(rst_o), 32'(exp_rst(m_prog)));
            chk("model ready_o", 32'(ready), 32'(m_prog >= PROG_MAX));
            chk("model fault_latched_o", 32'(lat), 32'(m_lat));
            chk("model restart_cnt_o", 32'(rcnt), (m_raw > 65535) ? 32'd65535 : 32'(m_raw));
            chk("model sat restart_cnt_o", 32'(s_rcnt), (m_raw > 7) ? 32'd7 : 32'(m_raw));
            chk("model sat rst_o", 32'(s_rst_o), 32'(exp_rst(m_prog)));
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_edges(2);
        chk("reset rst_o", 32'(rst_o), 32'd7);
        chk("reset ready_o", 32'(ready), 32'd0);
        chk("reset restart", 32'(rcnt), 32'd0);

        // Clean bring-up: E is the first edge after rst_r drops.
        rst_r = 1'b0;
        wait_edges(4);  chk("bringup E+3 rst_o", 32'(rst_o), 32'd7);
        wait_edges(1);  chk("bringup E+4 rst_o", 32'(rst_o), 32'd6);
        wait_edges(7);  chk("bringup E+11 rst_o", 32'(rst_o), 32'd6);
        wait_edges(1);  chk("bringup E+12 rst_o", 32'(rst_o), 32'd4);
        wait_edges(8);  chk("bringup E+20 rst_o", 32'(rst_o), 32'd0);
        wait_edges(7);  chk("bringup E+27 ready", 32'(ready), 32'd0);
        wait_edges(1);  chk("bringup E+28 ready", 32'(ready), 32'd1);
        chk("bringup restart", 32'(rcnt), 32'd0);

        // Fault in RUN via synchronised source.
        src[0] = 1'b1;
        wait_edges(2);  chk("run fault +2 ready", 32'(ready), 32'd1);
        wait_edges(1);  chk("run fault +3 rst_o", 32'(rst_o), 32'd7);
        chk("run fault +3 ready", 32'(ready), 32'd0);
        chk("run fault restart", 32'(rcnt), 32'd1);
        src[0] = 1'b0;
        wait_edges(6);  chk("rerelease rst_o hold", 32'(rst_o), 32'd7);
        wait_edges(1);  chk("rerelease rst_o[0]", 32'(rst_o), 32'd6);
        wait_edges(30); chk("rerelease ready", 32'(ready), 32'd1);

        // Force from RUN, then glitch during FILTER.
        force_rst = 1'b1;
        wait_edges(1);  chk("force latency rst_o", 32'(rst_o), 32'd7);
        chk("force restart", 32'(rcnt), 32'd2);
        force_rst = 1'b0; clear = 1'b1;
        wait_edges(1);  clear = 1'b0;
        wait_edges(1);  src[1] = 1'b1;
        wait_edges(1);  src[1] = 1'b0;
        wait_edges(1);
        wait_edges(1);  chk("glitch T+4 rst_o", 32'(rst_o), 32'd7);
        chk("glitch restart", 32'(rcnt), 32'd2);
        chk("glitch latched", 32'(lat), 32'd2);
        wait_edges(4);  chk("post glitch hold", 32'(rst_o), 32'd7);
        wait_edges(1);  chk("post glitch rst_o[0]", 32'(rst_o), 32'd6);
        wait_edges(30); chk("post glitch ready", 32'(ready), 32'd1);

        // Masked source held active.
        force_rst = 1'b1;
        wait_edges(1);  force_rst = 1'b0; mask = 3'b100; src[2] = 1'b1;
        wait_edges(29); chk("masked ready", 32'(ready), 32'd1);
        chk("masked latched", 32'(lat), 32'd2);
        chk("masked restart", 32'(rcnt), 32'd3);
        mask = 3'b000;
        wait_edges(1);  chk("unmask rst_o", 32'(rst_o), 32'd7);
        chk("unmask restart", 32'(rcnt), 32'd4);
        chk("unmask latched", 32'(lat), 32'd6);
        src[2] = 1'b0;

        // Clock-enable stall during RELEASE.
        wait_edges(4);  force_rst = 1'b1;
        wait_edges(1);  force_rst = 1'b0;
        wait_edges(7);  chk("stall T+6 rst_o", 32'(rst_o), 32'd6);
        cen = 1'b0;
        wait_edges(5);  cen = 1'b1;
        wait_edges(5);  chk("stall T+16 rst_o", 32'(rst_o), 32'd6);
        wait_edges(1);  chk("stall T+17 rst_o", 32'(rst_o), 32'd4);
        wait_edges(8);  chk("stall T+25 rst_o", 32'(rst_o), 32'd0);
        chk("stall T+25 ready", 32'(ready), 32'd0);
        cen = 1'b0; force_rst = 1'b1;
        wait_edges(1);  chk("force cen0 rst_o", 32'(rst_o), 32'd7);
        chk("force cen0 restart", 32'(rcnt), 32'd5);
        cen = 1'b1; force_rst = 1'b0;

        // Repeated restarts from RUN saturate the narrow counter.
        for (int n = 0; n < 8; n++) begin
            wait_edges(30); chk("sat loop ready", 32'(ready), 32'd1);
            force_rst = 1'b1;
            wait_edges(1);  force_rst = 1'b0;
        end
        chk("sat wide restart", 32'(rcnt), 32'd13);
        chk("sat narrow restart", 32'(s_rcnt), 32'd7);

        // Clear coinciding with a new set of bit 0.
        chk("pre clear latched", 32'(lat), 32'd6);
        src[0] = 1'b1;
        wait_edges(2);  clear = 1'b1;
        wait_edges(1);  clear = 1'b0; src[0] = 1'b0;
        chk("clear vs set latched", 32'(lat), 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N_SRC; b++)
                if ($urandom_range(149) == 0) src[b] = ~src[b];
            force_rst = ($urandom_range(399) == 0);
            clear     = ($urandom_range(99) == 0);
            cen       = ($urandom_range(7) != 0);
            rst_r     = ($urandom_range(1999) == 0);
            if ($urandom_range(499) == 0) mask = 3'($urandom_range(7));
            wait_edges(1);
        end
        rst_r = 1'b0; force_rst = 1'b0; clear = 1'b0; cen = 1'b1;
        wait_edges(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
